// File: rtl/approx_mac_acc.sv
// approx_mac_acc: frame accumulator for approximate-multiplier products; define APPROX_MAC_SAT_EN to saturate acc on overflow instead of wrapping
module approx_mac_acc #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_precise,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_approx,
    output logic             out_ovf,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             xfer;
    logic             last;

    assign in_ready  = state == ACC;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign xfer      = in_valid && in_ready;
    assign last      = out_count == len_q - CNT_W'(1);
    assign sum       = {1'b0, out_acc} + (ACC_W+1)'(in_prod);
`ifdef APPROX_MAC_SAT_EN
    assign acc_nxt   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign acc_nxt   = sum[ACC_W-1:0];
`endif

    // Frame sequencing plus accumulation; result registers double as the output ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            out_acc    <= '0;
            out_count  <= '0;
            out_approx <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    out_acc    <= '0;
                    out_count  <= '0;
                    out_approx <= 1'b0;
                    out_ovf    <= 1'b0;
                    len_q      <= len;
                    state      <= (len == '0) ? DONE : ACC;
                end
                ACC: if (xfer) begin
                    out_acc   <= acc_nxt;
                    out_count <= out_count + CNT_W'(1);
                    if (!in_precise) out_approx <= 1'b1;
                    if (sum[ACC_W]) out_ovf <= 1'b1;
                    if (last) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_mac_acc.sv
// tb_approx_mac_acc: directed checks of approx_mac_acc at ACC_W=40 and ACC_W=33
module tb_approx_mac_acc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_prod = '0;
    logic        in_precise = 1'b1;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_approx, out_ovf, busy;
    logic [39:0] out_acc;
    logic [7:0]  out_count;
    logic        s_in_ready, s_out_valid, s_out_approx, s_out_ovf, s_busy;
    logic [32:0] s_out_acc;
    logic [7:0]  s_out_count;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_mac_acc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_precise(in_precise),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count),
        .out_approx(out_approx), .out_ovf(out_ovf), .busy(busy)
    );

    approx_mac_acc #(.ACC_W(33)) dut33 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_prod(in_prod), .in_precise(in_precise),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc), .out_count(s_out_count),
        .out_approx(s_out_approx), .out_ovf(s_out_ovf), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [7:0] n);
        start = 1'b1;
        len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] p, input logic precise);
        int n = 0;
        in_valid = 1'b1;
        in_prod = p;
        in_precise = precise;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_timeout", 64'(n < 20), 64'd1);
        tick();
        in_valid = 1'b0;
        in_precise = 1'b1;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_acc", 64'(out_acc), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        chk("rst_flags", 64'({out_approx, out_ovf}), 64'd0);
        rst_n = 1'b1;
        tick();

        begin_frame(8'd3);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        send(32'h0001_0000, 1'b1);
        send(32'h0000_0005, 1'b1);
        chk("t1_not_done_early", 64'(out_valid), 64'd0);
        send(32'hFFFF_FFFF, 1'b1);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_acc", 64'(out_acc), 64'h01_0001_0004);
        chk("t1_count", 64'(out_count), 64'd3);
        chk("t1_approx", 64'(out_approx), 64'd0);
        chk("t1_ovf", 64'(out_ovf), 64'd0);
        release_result();
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_idle_valid", 64'(out_valid), 64'd0);
        chk("t1_retain_acc", 64'(out_acc), 64'h01_0001_0004);

        in_valid = 1'b1;
        begin_frame(8'd0);
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        chk("t2_acc", 64'(out_acc), 64'd0);
        chk("t2_count", 64'(out_count), 64'd0);
        in_valid = 1'b0;
        release_result();

        begin_frame(8'd2);
        tick();
        tick();
        send(32'h10, 1'b1);
        tick();
        send(32'h20, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_acc", 64'(out_acc), 64'h30);
            chk("t3_hold_count", 64'(out_count), 64'd2);
            tick();
        end
        release_result();
        chk("t3_idle", 64'(busy), 64'd0);

        begin_frame(8'd3);
        send(32'hFFFF_FFFF, 1'b1);
        send(32'hFFFF_FFFF, 1'b1);
        send(32'hFFFF_FFFF, 1'b1);
        chk("t4_valid33", 64'(s_out_valid), 64'd1);
        chk("t4_ovf33", 64'(s_out_ovf), 64'd1);
`ifdef APPROX_MAC_SAT_EN
        chk("t4_acc33", 64'(s_out_acc), 64'h1_FFFF_FFFF);
`else
        chk("t4_acc33", 64'(s_out_acc), 64'h0_FFFF_FFFD);
`endif
        chk("t4_count33", 64'(s_out_count), 64'd3);
        chk("t4_acc40", 64'(out_acc), 64'h2_FFFF_FFFD);
        chk("t4_ovf40", 64'(out_ovf), 64'd0);
        release_result();

        begin_frame(8'd3);
        send(32'd1, 1'b1);
        start = 1'b1;
        len = 8'd9;
        tick();
        start = 1'b0;
        send(32'd2, 1'b0);
        send(32'd4, 1'b1);
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_count", 64'(out_count), 64'd3);
        chk("t5_acc", 64'(out_acc), 64'd7);
        chk("t5_approx", 64'(out_approx), 64'd1);
        start = 1'b1;
        len = 8'd5;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        chk("t5_start_on_handshake", 64'(busy), 64'd0);
        chk("t5_retain_count", 64'(out_count), 64'd3);

        begin_frame(8'd4);
        send(32'd9, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_acc", 64'(out_acc), 64'd0);
        chk("t6_rst_count", 64'(out_count), 64'd0);
        chk("t6_rst_approx", 64'(out_approx), 64'd0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_valid", 64'(out_valid), 64'd0);
        end
        begin_frame(8'd1);
        send(32'd7, 1'b1);
        chk("t6_valid", 64'(out_valid), 64'd1);
        chk("t6_acc", 64'(out_acc), 64'd7);
        chk("t6_count", 64'(out_count), 64'd1);
        release_result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
